d_cache_sa: RTL and testbench



---
 rtl/d_cache_sa.sv | 155 +++++++++++++++
 tb/tb_d_cache_sa.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_sa.sv
// d_cache_sa: 1/2-way write-back write-allocate L1 data cache with multi-word lines and per-set LRU.
// Define D_CACHE_PERF_CNT_EN to add saturating perf_hit/perf_miss/perf_wb counters.
module d_cache_sa #(
    parameter int A_WIDTH    = 32,
    parameter int C_INDEX    = 6,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic [31:0]        p_dout,
    output logic [31:0]        p_din,
    input  logic               p_strobe,
    input  logic [3:0]         p_wen,
    input  logic [1:0]         p_size,
    input  logic               p_rw,
    output logic               p_ready,
    output logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_dout,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    input  logic               m_ready,
    input  logic               uncached
`ifdef D_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_hit,
    output logic [31:0]        perf_miss,
    output logic [31:0]        perf_wb
`endif
);
    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int OW   = OFF > 0 ? OFF : 1;
    localparam int SETS = 1 << C_INDEX;
    localparam int TW   = A_WIDTH - OFF - C_INDEX - 2;
    typedef enum logic [1:0] {IDLE, WB, RF} state_t;
    state_t state, nxt;
    logic [OW-1:0] cnt, off;
    logic [C_INDEX-1:0] idx;
    logic [TW-1:0] tag;
    logic [TW-1:0] tags [WAYS][SETS];
    logic [31:0] data [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0] valid [WAYS];
    logic [SETS-1:0] dirty [WAYS];
    logic [SETS-1:0] lru;
    logic [WAYS-1:0] wh;
    logic hw, vsel, vic, hit, miss, last;
    logic [A_WIDTH-1:0] cnt_a;
    assign off   = OFF > 0 ? OW'(p_a >> 2) : '0;
    assign idx   = C_INDEX'(p_a >> (OFF + 2));
    assign tag   = TW'(p_a >> (OFF + C_INDEX + 2));
    assign cnt_a = A_WIDTH'({cnt, 2'b00});
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign wh[g] = valid[g][idx] && tags[g][idx] == tag;
    end
    assign hw   = WAYS > 1 ? wh[WAYS-1] & ~wh[0] : 1'b0;
    // An invalid way is always preferred over the LRU way
    assign vsel = !valid[0][idx] ? 1'b0 : (WAYS > 1 && !valid[WAYS-1][idx]) ? 1'b1 : WAYS > 1 ? lru[idx] : 1'b0;
    assign hit  = p_strobe & ~uncached & (state == IDLE) & (|wh);
    assign miss = p_strobe & ~uncached & (state == IDLE) & ~(|wh);
    assign last = cnt == OW'(LINE_WORDS - 1);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt      = state;
        p_ready  = 1'b0;
        p_din    = data[hw][idx][off];
        m_a      = p_a;
        m_din    = p_dout;
        m_strobe = 1'b0;
        m_wen    = p_wen;
        m_size   = p_size;
        m_rw     = p_rw;
        case (state)
            IDLE: begin
                if (p_strobe & uncached) begin
                    m_strobe = 1'b1;
                    p_din    = m_dout;
                    p_ready  = m_ready;
                end else if (hit) p_ready = 1'b1;
                else if (miss) nxt = (valid[vsel][idx] && dirty[vsel][idx]) ? WB : RF;
            end
            WB: begin
                m_strobe = 1'b1;
                m_rw     = 1'b1;
                m_wen    = 4'b1111;
                m_size   = 2'b10;
                m_a      = {tags[vic][idx], idx, {(OFF + 2){1'b0}}} | cnt_a;
                m_din    = data[vic][idx][cnt];
                if (m_ready && last) nxt = RF;
            end
            RF: begin
                m_strobe = 1'b1;
                m_rw     = 1'b0;
                m_wen    = 4'b1111;
                m_size   = 2'b10;
                m_a      = {tag, idx, {(OFF + 2){1'b0}}} | cnt_a;
                if (m_ready && last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            vic <= 1'b0;
            lru <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
        end else begin
            if (miss) begin
                cnt <= '0;
                vic <= vsel;
            end
            if (state != IDLE && m_ready) cnt <= last ? '0 : cnt + 1'b1;
            if (hit) begin
                lru[idx] <= ~hw;
                if (p_rw) dirty[hw][idx] <= 1'b1;
            end
            if (state == RF && m_ready && last) begin
                valid[vic][idx] <= 1'b1;
                dirty[vic][idx] <= 1'b0;
                lru[idx]        <= ~vic;
            end
        end
    end
    // Tag and data storage carries no reset; validity guards it
    always_ff @(posedge clk) begin
        if (hit && p_rw)
            for (int b = 0; b < 4; b++)
                if (p_wen[b]) data[hw][idx][off][8*b +: 8] <= p_dout[8*b +: 8];
        if (state == RF && m_ready) data[vic][idx][cnt] <= m_dout;
        if (state == RF && m_ready && last) tags[vic][idx] <= tag;
    end
`ifdef D_CACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
            perf_wb   <= '0;
        end else begin
            if (hit && !(&perf_hit)) perf_hit <= perf_hit + 1'b1;
            if (miss && !(&perf_miss)) perf_miss <= perf_miss + 1'b1;
            if (state == WB && m_ready && last && !(&perf_wb)) perf_wb <= perf_wb + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_d_cache_sa.sv
// tb_d_cache_sa: scoreboard bench for d_cache_sa against a flat-memory and recency-list cache model.
module tb_d_cache_sa;
    localparam int L = 4;
    localparam int W = 2;
    logic clk = 0, rst = 1;
    logic [31:0] p_a = 0, p_dout = 0, p_din, m_a, m_dout = 0, m_din;
    logic p_strobe = 0, p_rw = 0, p_ready, m_strobe, m_rw, m_ready = 0, uncached = 0;
    logic [3:0] p_wen = 0, m_wen;
    logic [1:0] p_size = 0, m_size;
    int total = 0, bad = 0, cyc = 0, last_hs = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] refm [logic [31:0]];
    logic [31:0] rd_log[$], wr_log[$], sb[$];
    logic [31:0] e;
    typedef struct {int unsigned tag; bit dirty;} line_t;
    line_t sets [64][$];

    d_cache_sa dut (.clk(clk), .rst(rst), .p_a(p_a), .p_dout(p_dout), .p_din(p_din), .p_strobe(p_strobe),
        .p_wen(p_wen), .p_size(p_size), .p_rw(p_rw), .p_ready(p_ready), .m_a(m_a), .m_dout(m_dout),
        .m_din(m_din), .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
        .m_ready(m_ready), .uncached(uncached));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] rrd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        for (int b = 0; b < 4; b++) if (w[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // Bus slave: random wait states, plus stray m_ready pulses while the bus is idle
    initial forever begin
        logic [31:0] wa;
        @(posedge clk);
        #2;
        m_ready = 0;
        wa = {m_a[31:2], 2'b00};
        if (m_strobe && $urandom_range(2) != 0) begin
            m_ready = 1;
            last_hs = cyc;
            if (m_rw) begin
                mem[wa] = merge(mrd(wa), m_din, m_wen);
                wr_log.push_back(m_a);
            end else begin
                m_dout = mrd(wa);
                rd_log.push_back(m_a);
            end
        end else if (!m_strobe && $urandom_range(7) == 0) begin
            m_ready = 1;
            m_dout = $urandom;
        end
    end

    always @(negedge clk)
        if (!rst && p_strobe && p_ready && !p_rw) begin
            if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 1);
            else begin
                e = sb.pop_front();
                chk("load_data", p_din, e);
            end
        end

    task automatic access(input logic [31:0] a, input bit rw, input logic [3:0] wen, input logic [31:0] d,
                          input bit unc, input logic [1:0] sz);
        logic [31:0] wa, er[$], ew[$];
        bit hitp, ok;
        int idx, k, st, n;
        int unsigned tg;
        line_t ln;
        wa = {a[31:2], 2'b00};
        hitp = 0;
        if (!unc) begin
            idx = int'((a >> 4) & 63);
            tg = a >> 10;
            k = -1;
            for (int i = 0; i < sets[idx].size(); i++) if (sets[idx][i].tag == tg) k = i;
            if (k >= 0) begin
                hitp = 1;
                ln = sets[idx][k];
                sets[idx].delete(k);
                ln.dirty = ln.dirty | rw;
                sets[idx].push_front(ln);
            end else begin
                if (sets[idx].size() == W) begin
                    ln = sets[idx].pop_back();
                    if (ln.dirty) for (int i = 0; i < L; i++) ew.push_back(32'((ln.tag << 10) | (idx << 4) | (i * 4)));
                end
                for (int i = 0; i < L; i++) er.push_back(32'((tg << 10) | (idx << 4) | (i * 4)));
                ln.tag = tg;
                ln.dirty = rw;
                sets[idx].push_front(ln);
            end
        end
        if (rw) refm[wa] = merge(rrd(wa), d, wen);
        else sb.push_back(rrd(wa));
        p_a = a; p_rw = rw; p_wen = wen; p_dout = d; p_size = sz; uncached = unc; p_strobe = 1;
        rd_log.delete();
        wr_log.delete();
        st = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (unc) chk("unc_mirror", {m_strobe, m_a == a, m_din == d, m_wen == wen, m_size == sz, m_rw == rw, p_ready == m_ready}, 7'h7F);
            else if (hitp) chk("hit_no_strobe", m_strobe, 0);
        end while (!p_ready && n < 400);
        if (!p_ready) chk("timeout", p_ready, 1);
        if (!unc) begin
            chk("n_rd", rd_log.size(), er.size());
            chk("n_wr", wr_log.size(), ew.size());
            ok = rd_log.size() == er.size() && wr_log.size() == ew.size();
            if (ok) begin
                foreach (er[i]) if (rd_log[i] != er[i]) ok = 0;
                foreach (ew[i]) if (wr_log[i] != ew[i]) ok = 0;
            end
            chk("bus_addrs", ok, 1);
            if (hitp) chk("hit_latency", cyc - st, 0);
            else chk("miss_latency", cyc - last_hs, 1);
        end
        @(posedge clk);
        #1;
        p_strobe = 0;
        uncached = 0;
    endtask

    task automatic idle();
        @(negedge clk);
        chk("idle_no_strobe", m_strobe, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, ix;
        bit unc, rw;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            mem[32'h1000 + 4 * i] = 32'h11 * (i + 1);
            refm[32'h1000 + 4 * i] = 32'h11 * (i + 1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p_ready", p_ready, 0);
        chk("rst_m_strobe", m_strobe, 0);
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        access(32'h0000_1004, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_1008, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_1004, 1, 4'b0101, 32'hAABB_CCDD, 0, 2'b10);
        chk("merge_model", rrd(32'h1004), 32'h00BB_00DD);
        access(32'h0000_1004, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_1000, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_2000, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_3000, 0, 4'hF, 0, 0, 2'b10);
        access(32'h0000_1004, 0, 4'hF, 0, 0, 2'b10);
        access(32'hBFD0_0000, 1, 4'b0001, 32'h1234_56A5, 1, 2'b00);
        access(32'hBFD0_0000, 0, 4'hF, 0, 1, 2'b10);
        access(32'hBFD0_0000, 0, 4'hF, 0, 0, 2'b10);
        p_a = 32'h0000_5040; p_rw = 0; p_wen = 4'hF; uncached = 0; p_strobe = 1;
        rd_log.delete();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_log.size() < 2 && n < 400);
        chk("rst_reach_word2", rd_log.size(), 2);
        rst = 1;
        p_strobe = 0;
        @(negedge clk);
        chk("abort_m_strobe", m_strobe, 0);
        chk("abort_p_ready", p_ready, 0);
        rst = 0;
        foreach (sets[i]) sets[i].delete();
        @(posedge clk);
        #1;
        access(32'h0000_5040, 0, 4'hF, 0, 0, 2'b10);
        for (int i = 0; i < 300; i++) begin
            unc = $urandom_range(7) == 0;
            rw = $urandom_range(2) == 0;
            ix = $urandom_range(3);
            if (ix == 3) ix = 63;
            a = unc ? 32'hBFD0_0100 + 32'($urandom_range(15)) * 4
                    : 32'(($urandom_range(5) << 10) | (ix << 4) | ($urandom_range(3) << 2));
            access(a, rw, 4'($urandom_range(15)), $urandom, unc, 2'($urandom_range(3)));
            if ($urandom_range(3) == 0) idle();
        end
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
